// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect, and the decode handshake.
// master is the fetch stage; slave is the surrounding memory/decode/control.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            valid_o;
    logic            ready_i;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] pc_o;

    modport master (
        output imem_req_valid, imem_req_addr, valid_o, inst_o, pc_o,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               ready_i
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, valid_o, inst_o, pc_o,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               ready_i
    );
endinterface

// File: rtl/fetch_stage.sv
// In-order instruction fetch: owns the PC, credit-limits memory requests, buffers responses.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module fetch_stage #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     IBUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus_io
);
    localparam int unsigned CntW = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;
    localparam int unsigned PtrW = $clog2(IBUF_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]     inst_mem_q [IBUF_DEPTH];
    logic [XLEN-1:0] pc_mem_q   [IBUF_DEPTH];
    logic            active_q;

    logic            empty;
    logic            rsp_keep;
    logic            push;
    logic            pop;
    logic            pop_buf;
    logic            valid;
    logic            req_valid;
    logic            req_fire;
    logic [OccW-1:0] occupancy;
    logic [OccW-1:0] limit;
    logic [XLEN-1:0] redirect_target;

    assign empty    = (count_q == '0);
    assign rsp_keep = bus_io.imem_rsp_valid & (drop_cnt_q == '0) & ~bus_io.redirect_valid;
    assign redirect_target = bus_io.redirect_pc & ~XLEN'(3);

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass         = rsp_keep & empty;
    assign valid          = (~empty | bypass) & ~bus_io.redirect_valid;
    assign bus_io.inst_o  = bypass ? bus_io.imem_rsp_data : inst_mem_q[rd_ptr_q];
    assign bus_io.pc_o    = bypass ? rsp_pc_q : pc_mem_q[rd_ptr_q];
    // A bypassed response taken by decode never occupies a slot.
    assign push           = rsp_keep & ~(bypass & bus_io.ready_i);
`else
    assign valid          = ~empty & ~bus_io.redirect_valid;
    assign bus_io.inst_o  = inst_mem_q[rd_ptr_q];
    assign bus_io.pc_o    = pc_mem_q[rd_ptr_q];
    assign push           = rsp_keep;
`endif

    assign pop     = valid & bus_io.ready_i;
    assign pop_buf = pop & ~empty;

    // Every request in flight owns a buffer slot, so responses never need back-pressure.
    assign occupancy = OccW'(outstanding_q) + OccW'(count_q);
    assign limit     = OccW'(IBUF_DEPTH) + OccW'(pop);
    assign req_valid = active_q & ~bus_io.redirect_valid & (occupancy < limit);
    assign req_fire  = req_valid & bus_io.imem_req_ready;

    assign bus_io.imem_req_valid = req_valid;
    assign bus_io.imem_req_addr  = pc_q;
    assign bus_io.valid_o        = valid;

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(bus_io.imem_rsp_valid);

        if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        if (bus_io.redirect_valid) begin
            pc_d       = redirect_target;
            rsp_pc_d   = redirect_target;
            drop_cnt_d = outstanding_q - CntW'(bus_io.imem_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (bus_io.imem_rsp_valid && drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - CntW'(1);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_buf) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop_buf);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            active_q      <= 1'b0;
            for (int i = 0; i < int'(IBUF_DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            active_q      <= 1'b1;
            if (push) begin
                inst_mem_q[wr_ptr_q] <= bus_io.imem_rsp_data;
                pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected {pc} entries; a monitor
// pops and compares on every decode handshake.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(32)) bus ();
    fetch_stage_if #(.XLEN(32)) bus2 ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .IBUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );
    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .IBUF_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .bus_io(bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int npop = 0;
    int npop2 = 0;
    int grant_total = 0;
    int grant2_total = 0;
    bit mem_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model for dut: in-order, responds the cycle after a request when enabled.
    initial begin
        logic [31:0] mq[$];
        logic        fire_s;
        logic [31:0] fire_addr;
        int          granted;
        granted = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            fire_s    = bus.imem_req_valid & bus.imem_req_ready;
            fire_addr = bus.imem_req_addr;
            if (fire_s) granted++;
            @(posedge clk);
            #1;
            if (rst) begin
                mq.delete();
                bus.imem_rsp_valid = 1'b0;
                bus.imem_req_ready = 1'b0;
                continue;
            end
            if (fire_s) mq.push_back(fire_addr);
            if (mem_en && mq.size() > 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = inst_of(mq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
            bus.imem_req_ready = (granted < grant_total);
        end
    end

    // Fixed 1-cycle memory for dut2.
    initial begin
        logic        fire_s;
        logic [31:0] fire_addr;
        int          granted;
        granted = 0;
        bus2.imem_req_ready = 1'b0;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            fire_s    = bus2.imem_req_valid & bus2.imem_req_ready;
            fire_addr = bus2.imem_req_addr;
            if (fire_s) granted++;
            @(posedge clk);
            #1;
            bus2.imem_rsp_valid = fire_s & ~rst;
            bus2.imem_rsp_data  = inst_of(fire_addr);
            bus2.imem_req_ready = ~rst & (granted < grant2_total);
        end
    end

    // Monitor: scoreboard pops, hold stability, counter bounds.
    initial begin
        logic        hold;
        logic [31:0] hold_pc;
        logic [31:0] hold_inst;
        logic [31:0] e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (hold && bus.valid_o) begin
                    check("hold_pc", bus.pc_o, hold_pc);
                    check("hold_inst", bus.inst_o, hold_inst);
                end
                hold      = bus.valid_o & ~bus.ready_i;
                hold_pc   = bus.pc_o;
                hold_inst = bus.inst_o;
                if (bus.valid_o && bus.ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pop_extra: got pc %0h want no instruction", bus.pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_pc", bus.pc_o, e);
                        check("pop_inst", bus.inst_o, inst_of(e));
                    end
                    npop++;
                end
                n_cmp++;
                if (dut.outstanding_q > 2 || dut.drop_cnt_q > dut.outstanding_q) begin
                    n_bad++;
                    $display("FAIL counters: got outstanding %0d drop %0d want <=2 and drop<=out",
                             dut.outstanding_q, dut.drop_cnt_q);
                end
                if (bus2.valid_o && bus2.ready_i) begin
                    if (exp2_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pop2_extra: got pc %0h want no instruction", bus2.pc_o);
                    end else begin
                        e = exp2_q.pop_front();
                        check("pop2_pc", bus2.pc_o, e);
                        check("pop2_inst", bus2.inst_o, inst_of(e));
                    end
                    npop2++;
                end
            end
        end
    end

    task automatic wait_pops(input int target, input int limit, input string name);
        int n = 0;
        while (npop < target && n < limit) begin
            @(posedge clk);
            #3;
            n++;
        end
        check(name, npop, target);
    endtask

    initial begin
        int  first_cyc;
        int  n;
        bit  found;
        bus.ready_i         = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus2.ready_i        = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;

        // Reset state
        #12;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_valid_o", bus.valid_o, 0);
        check("rst_inst_o", bus.inst_o, 0);
        check("rst_pc_o", bus.pc_o, 0);
        check("rst2_req_valid", bus2.imem_req_valid, 0);
        check("rst2_valid_o", bus2.valid_o, 0);
        check("rst2_pc_o", bus2.pc_o, 0);
        check("rst_outstanding", dut.outstanding_q, 0);

        // Streaming 8 instructions with ready_i=1
        grant_total = 8;
        bus.ready_i = 1'b1;
        mem_en      = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", bus.imem_req_valid, 1);
        check("first_req_addr", bus.imem_req_addr, 32'h0);
        check("first_valid_o", bus.valid_o, 0);
        wait_pops(1, 20, "stream_first");
        first_cyc = cyc;
        wait_pops(8, 20, "stream_all");
        check("stream_back_to_back", cyc - first_cyc, 7);

        // Back-pressure for 10 cycles
        bus.ready_i = 1'b0;
        grant_total = 28;
        for (int i = 0; i < 20; i++) exp_q.push_back(32'h20 + 32'(i * 4));
        repeat (10) @(posedge clk);
        #3;
        check("bp_req_stopped", bus.imem_req_valid, 0);
        check("bp_credit_full", 32'(dut.outstanding_q) + 32'(dut.count_q), 2);
        bus.ready_i = 1'b1;
        wait_pops(28, 80, "bp_drain");

        // Redirect with two requests outstanding
        mem_en      = 1'b0;
        grant_total = 30;
        n = 0;
        while (dut.outstanding_q != 2 && n < 20) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("two_outstanding", dut.outstanding_q, 2);
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        grant_total        = 34;
        #3;
        check("redir_no_req", bus.imem_req_valid, 0);
        check("redir_no_valid", bus.valid_o, 0);
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        mem_en             = 1'b1;
        #1;
        check("redir_addr", bus.imem_req_addr, 32'h100);
        check("redir_drop_cnt", dut.drop_cnt_q, 2);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        wait_pops(32, 40, "redir_drain");

        // Redirect colliding with a response and a ready decode; unaligned target
        grant_total = 37;
        exp_q.push_back(32'h110);
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            @(posedge clk);
            #2;
            found = bus.imem_rsp_valid && bus.imem_rsp_data == inst_of(32'h118) && bus.valid_o;
            n++;
        end
        check("collide_found", found, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        grant_total        = 39;
        #3;
        check("collide_no_valid", bus.valid_o, 0);
        check("collide_no_req", bus.imem_req_valid, 0);
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        #1;
        check("collide_drop_cnt", dut.drop_cnt_q, 0);
        check("collide_addr", bus.imem_req_addr, 32'h200);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        wait_pops(35, 40, "collide_drain");

        // PC wrap from RESET_PC=0xFFFF_FFF8
        exp2_q.push_back(32'hFFFF_FFF8);
        exp2_q.push_back(32'hFFFF_FFFC);
        exp2_q.push_back(32'h0000_0000);
        grant2_total = 3;
        n = 0;
        while (npop2 < 3 && n < 30) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("wrap_pops", npop2, 3);

        repeat (5) @(posedge clk);
        #3;
        check("exp_empty", exp_q.size(), 0);
        check("exp2_empty", exp2_q.size(), 0);
        check("final_valid_o", bus.valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the in-order RISC-V pipeline, directly upstream of the decode stage.
- Owns the PC and issues in-order requests to the instruction memory port.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) that flushes buffered and in-flight fetches.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h0000_0000, PC fetched first after reset (low 2 bits must be 0)
IBUF_DEPTH, 2, instruction buffer entries; power of 2, >= 2; also the cap on outstanding+buffered fetches

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address (word aligned)
imem_rsp_valid  input  1  response valid; in order; cannot be back-pressured
imem_rsp_data  input  32  fetched instruction
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  XLEN  new PC; bits [1:0] ignored (forced 0)
valid_o  output  1  instruction valid to decode
ready_i  input  1  decode ready (decode's ready_o)
inst_o  output  32  instruction at buffer head
pc_o  output  XLEN  PC of inst_o

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, rsp_pc=RESET_PC.
  - Buffer empty; outstanding=0, drop_cnt=0.
  - Outputs: imem_req_valid=0, valid_o=0, inst_o=0, pc_o=0.
- Reset mid-operation clears all state immediately. In-flight responses arriving after reset release are NOT dropped; the memory is also reset by rst, so none occur.
- Credit:
  - pop = valid_o & ready_i.
  - imem_req_valid = ~rst_sync_first_cycle & ~redirect_valid & (outstanding + count - pop < IBUF_DEPTH).
  - Guarantees every response has a free slot, so imem_rsp_valid is always accepted.
- Request:
  - Fires on imem_req_valid & imem_req_ready: outstanding+1, pc += 4 (mod 2^XLEN; 0xFFFF_FFFC wraps to 0).
  - imem_req_addr = pc, held stable while stalled.
- Response:
  - If drop_cnt != 0: discard and decrement drop_cnt.
  - Otherwise push {rsp_pc, imem_rsp_data} and rsp_pc += 4.
  - outstanding-1 in both cases. Request and response in the same cycle leave outstanding unchanged.
- Output:
  - valid_o = ~empty & ~redirect_valid.
  - inst_o/pc_o show the head entry, stable while valid_o & ~ready_i.
  - Push and pop in the same cycle are allowed, including when full (pop frees the slot).
  - Latency: response cycle N -> valid_o cycle N+1.
- Redirect (redirect_valid=1 in cycle R):
  - Buffer flushed; no pop, no request in R.
  - pc=rsp_pc=redirect_pc&~3.
  - drop_cnt = outstanding - (imem_rsp_valid ? 1 : 0). A response in R is discarded.
  - First request with the new PC in R+1.
  - Back-to-back redirects: the last one wins; drop_cnt recomputed each time.
- Throughput: 1 instr/cycle with 1-cycle memory, ready_i=1, IBUF_DEPTH>=2.
- Counters: outstanding and drop_cnt are clog2(IBUF_DEPTH+1) bits; never over/underflow by construction. Bench asserts this.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the buffer is empty, a non-dropped response appears on valid_o/inst_o/pc_o combinationally in the same cycle.
  - If ready_i=1 it is consumed without being written; otherwise it is written.
  - Latency 0 cycles from response.
- Undefined: no combinational rsp->valid_o path; latency 1 cycle as above.

Test Plan:
- Reset release, imem_req_ready=1 -> first imem_req_addr=0x0000_0000 in first cycle after reset; valid_o=0 until first response.
- 1-cycle memory, ready_i=1, 8 instrs -> valid_o every cycle after fill; pc_o 0x0,0x4,...,0x1C with matching inst_o.
- ready_i=0 for 10 cycles -> requests stop at outstanding+count=2; inst_o/pc_o stable; streaming resumes in order, no loss or duplication.
- 2 outstanding, redirect_pc=0x100 -> both responses dropped; next valid_o shows pc_o=0x100; first new request the cycle after redirect.
- Redirect in the same cycle as imem_rsp_valid and pop, redirect_pc=0x203 -> response dropped; pc_o=0x200 next; drop_cnt=outstanding-1.
- RESET_PC=0xFFFF_FFF8 -> pc_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
